button_press_classifier: RTL and testbench

//  Multi-channel button front end: synchronises, debounces and classifies each raw button

---
 rtl/press_pkg.sv | 18 +
 rtl/press_channel.sv | 117 +++++++++++
 rtl/button_press_classifier.sv | 41 ++++
 tb/tb_button_press_classifier.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/press_pkg.sv
// Shared types and default thresholds for the button press classifier.
// The optional auto-repeat feature is enabled by defining PRESS_REPEAT_EN.
package press_pkg;

   typedef enum logic [1:0] {
      WAIT_REL,
      IDLE,
      PRESSED,
      LONG_HELD
   } press_state_t;

   localparam int DEF_N_CH         = 4;
   localparam int DEF_CNT_W        = 28;
   localparam int DEF_DEBOUNCE_CYC = 1_000_000;
   localparam int DEF_LONG_CYC     = 200_000_000;
   localparam int DEF_REPEAT_CYC   = 25_000_000;

endpackage

// File: rtl/press_channel.sv
// One button channel: 2-flop synchroniser, debounce, and short/long/repeat classifier FSM.
// Auto-repeat logic exists only when PRESS_REPEAT_EN is defined.
module press_channel
   import press_pkg::*;
#(
   parameter int CNT_W        = DEF_CNT_W,
   parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
   parameter int LONG_CYC     = DEF_LONG_CYC,
   parameter int REPEAT_CYC   = DEF_REPEAT_CYC
)(
   input  logic clk_i,
   input  logic rst_i,
   input  logic button_i,
   output logic press_short_o,
   output logic press_long_o,
   output logic press_repeat_o,
   output logic held_o
);

   localparam int                DB_W      = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
   localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYC - 1);
   localparam logic [CNT_W-1:0]  LONG_LAST = CNT_W'(LONG_CYC);

   logic [1:0]       r_sync;
   logic             r_db;
   logic [DB_W-1:0]  r_db_cnt;
   logic [CNT_W-1:0] r_hold_cnt;
   press_state_t     r_state;
   logic             r_short;
   logic             r_long;

`ifdef PRESS_REPEAT_EN
   // Counter runs 0..REPEAT_CYC-1 so the first repeat lands REPEAT_CYC cycles after the long pulse.
   localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYC - 1);
   logic r_repeat;
`endif

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_sync     <= 2'b00;
         r_db       <= 1'b1;
         r_db_cnt   <= '0;
         r_hold_cnt <= '0;
         r_state    <= WAIT_REL;
         r_short    <= 1'b0;
         r_long     <= 1'b0;
`ifdef PRESS_REPEAT_EN
         r_repeat   <= 1'b0;
`endif
      end else begin
         r_sync  <= {r_sync[0], button_i};
         r_short <= 1'b0;
         r_long  <= 1'b0;
`ifdef PRESS_REPEAT_EN
         r_repeat <= 1'b0;
`endif

         if (r_sync[1] == r_db) begin
            r_db_cnt <= '0;
         end else if (r_db_cnt == DB_LAST) begin
            r_db     <= r_sync[1];
            r_db_cnt <= '0;
         end else begin
            r_db_cnt <= r_db_cnt + DB_W'(1);
         end

         case (r_state)
            WAIT_REL: begin
               if (!r_db) r_state <= IDLE;
            end
            IDLE: begin
               if (r_db) begin
                  r_state    <= PRESSED;
                  r_hold_cnt <= CNT_W'(1);
               end
            end
            PRESSED: begin
               // Release is tested first so it beats a simultaneous threshold hit.
               if (!r_db) begin
                  r_state <= IDLE;
                  r_short <= 1'b1;
               end else if (r_hold_cnt == LONG_LAST) begin
                  r_state    <= LONG_HELD;
                  r_long     <= 1'b1;
                  r_hold_cnt <= '0;
               end else begin
                  r_hold_cnt <= r_hold_cnt + CNT_W'(1);
               end
            end
            LONG_HELD: begin
               if (!r_db) begin
                  r_state <= IDLE;
               end
`ifdef PRESS_REPEAT_EN
               else if (r_hold_cnt == REP_LAST) begin
                  r_repeat   <= 1'b1;
                  r_hold_cnt <= '0;
               end else begin
                  r_hold_cnt <= r_hold_cnt + CNT_W'(1);
               end
`endif
            end
            default: r_state <= WAIT_REL;
         endcase
      end
   end

   assign press_short_o = r_short;
   assign press_long_o  = r_long;
   assign held_o        = r_db & (r_state != WAIT_REL);
`ifdef PRESS_REPEAT_EN
   assign press_repeat_o = r_repeat;
`else
   assign press_repeat_o = 1'b0;
`endif

endmodule

// File: rtl/button_press_classifier.sv
// Multi-channel button front end: N_CH independent press_channel instances.
// Define PRESS_REPEAT_EN to enable auto-repeat pulses while a button is long-held.
module button_press_classifier
   import press_pkg::*;
#(
   parameter int N_CH         = DEF_N_CH,
   parameter int CNT_W        = DEF_CNT_W,
   parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
   parameter int LONG_CYC     = DEF_LONG_CYC,
   parameter int REPEAT_CYC   = DEF_REPEAT_CYC
)(
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic [N_CH-1:0] button_i,
   output logic [N_CH-1:0] press_short_o,
   output logic [N_CH-1:0] press_long_o,
   output logic [N_CH-1:0] press_repeat_o,
   output logic [N_CH-1:0] held_o
);

   genvar gi;
   generate
      for (gi = 0; gi < N_CH; gi++) begin : g_ch
         press_channel #(
            .CNT_W        (CNT_W),
            .DEBOUNCE_CYC (DEBOUNCE_CYC),
            .LONG_CYC     (LONG_CYC),
            .REPEAT_CYC   (REPEAT_CYC)
         ) u_ch (
            .clk_i          (clk_i),
            .rst_i          (rst_i),
            .button_i       (button_i[gi]),
            .press_short_o  (press_short_o[gi]),
            .press_long_o   (press_long_o[gi]),
            .press_repeat_o (press_repeat_o[gi]),
            .held_o         (held_o[gi])
         );
      end
   endgenerate

endmodule

// File: tb/tb_button_press_classifier.sv
// Directed table-driven bench for button_press_classifier (N_CH=2, DEBOUNCE=4, LONG=20, REPEAT=8).
// Repeat expectations follow PRESS_REPEAT_EN.
module tb_button_press_classifier;

   localparam int N_CH = 2;
   localparam int DEB  = 4;
   localparam int LONG = 20;
   localparam int REP  = 8;
`ifdef PRESS_REPEAT_EN
   localparam int REP_40 = 2;
   localparam int REP_60 = 4;
`else
   localparam int REP_40 = 0;
   localparam int REP_60 = 0;
`endif

   logic            clk_i = 1'b0;
   logic            rst_i;
   logic [N_CH-1:0] button_i;
   logic [N_CH-1:0] press_short_o;
   logic [N_CH-1:0] press_long_o;
   logic [N_CH-1:0] press_repeat_o;
   logic [N_CH-1:0] held_o;

   button_press_classifier #(
      .N_CH(N_CH), .CNT_W(8), .DEBOUNCE_CYC(DEB), .LONG_CYC(LONG), .REPEAT_CYC(REP)
   ) dut (
      .clk_i(clk_i), .rst_i(rst_i), .button_i(button_i),
      .press_short_o(press_short_o), .press_long_o(press_long_o),
      .press_repeat_o(press_repeat_o), .held_o(held_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      int ch;
      int high;
      int exp_short;
      int exp_long;
      int exp_rep;
   } vec_t;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int n_short[N_CH], n_long[N_CH], n_rep[N_CH];
   int short_at[N_CH], long_at[N_CH], rep_first[N_CH], rep_last[N_CH];
   int held_rise[N_CH], held_fall[N_CH];
   logic [N_CH-1:0] prev_held = '0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic clear_stats();
      for (int c = 0; c < N_CH; c++) begin
         n_short[c] = 0; n_long[c] = 0; n_rep[c] = 0;
         short_at[c] = -1; long_at[c] = -1; rep_first[c] = -1; rep_last[c] = -1;
         held_rise[c] = -1; held_fall[c] = -1;
      end
   endtask

   task automatic step(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk_i);
         #1;
         cyc++;
         for (int c = 0; c < N_CH; c++) begin
            if (press_short_o[c]) begin n_short[c]++; short_at[c] = cyc; end
            if (press_long_o[c])  begin n_long[c]++;  long_at[c]  = cyc; end
            if (press_repeat_o[c]) begin
               n_rep[c]++;
               if (rep_first[c] < 0) rep_first[c] = cyc;
               rep_last[c] = cyc;
            end
            if (held_o[c] && !prev_held[c]) held_rise[c] = cyc;
            if (!held_o[c] && prev_held[c]) held_fall[c] = cyc;
            prev_held[c] = held_o[c];
         end
      end
   endtask

   function automatic int total(input int c);
      return n_short[c] + n_long[c] + n_rep[c];
   endfunction

   vec_t vecs[7];

   initial begin
      vecs[0] = '{0,  3, 0, 0, 0};       // glitch shorter than debounce
      vecs[1] = '{0, 12, 1, 0, 0};       // plain short press
      vecs[2] = '{1, 40, 0, 1, REP_40};  // long press on ch1
      vecs[3] = '{0, 20, 1, 0, 0};       // release on threshold cycle: short wins
      vecs[4] = '{0, 21, 0, 1, 0};       // one cycle more: long
      vecs[5] = '{1,  4, 1, 0, 0};       // minimum accepted press
      vecs[6] = '{0, 60, 0, 1, REP_60};  // long hold with repeats

      rst_i    = 1'b1;
      button_i = '0;
      clear_stats();
      step(3);
      chk("rst_short",  int'(press_short_o),  0);
      chk("rst_long",   int'(press_long_o),   0);
      chk("rst_repeat", int'(press_repeat_o), 0);
      chk("rst_held",   int'(held_o),         0);
      rst_i = 1'b0;
      step(20);

      for (int v = 0; v < 7; v++) begin
         int ch, oth;
         ch  = vecs[v].ch;
         oth = 1 - ch;
         clear_stats();
         button_i[ch] = 1'b1;
         step(vecs[v].high);
         button_i[ch] = 1'b0;
         step(40);
         $display("vec %0d ch=%0d high=%0d short=%0d long=%0d rep=%0d", v, ch, vecs[v].high,
                  n_short[ch], n_long[ch], n_rep[ch]);
         chk($sformatf("v%0d_short", v), n_short[ch], vecs[v].exp_short);
         chk($sformatf("v%0d_long", v),  n_long[ch],  vecs[v].exp_long);
         chk($sformatf("v%0d_rep", v),   n_rep[ch],   vecs[v].exp_rep);
         chk($sformatf("v%0d_other", v), total(oth),  0);
         chk($sformatf("v%0d_held_end", v), int'(held_o[ch]), 0);
         if (vecs[v].high < DEB)
            chk($sformatf("v%0d_no_held", v), held_rise[ch], -1);
         else
            chk($sformatf("v%0d_held_len", v), held_fall[ch] - held_rise[ch], vecs[v].high);
         if (vecs[v].exp_long > 0)
            chk($sformatf("v%0d_long_lat", v), long_at[ch] - held_rise[ch], LONG + 1);
         if (vecs[v].exp_short > 0)
            chk($sformatf("v%0d_short_lat", v), short_at[ch] - held_fall[ch], 1);
         if (vecs[v].exp_rep > 0) begin
            chk($sformatf("v%0d_rep_first", v), rep_first[ch] - long_at[ch], REP);
            chk($sformatf("v%0d_rep_span", v), rep_last[ch] - rep_first[ch], REP * (vecs[v].exp_rep - 1));
         end
      end

      // Both channels pressed together: shorts land in the same cycle.
      clear_stats();
      button_i = 2'b11;
      step(12);
      button_i = 2'b00;
      step(40);
      $display("dual short0=%0d@%0d short1=%0d@%0d", n_short[0], short_at[0], n_short[1], short_at[1]);
      chk("dual_short0", n_short[0], 1);
      chk("dual_short1", n_short[1], 1);
      chk("dual_same_cycle", short_at[0] - short_at[1], 0);

      // Button held through reset: silent until released, then classified normally.
      clear_stats();
      button_i = 2'b01;
      step(2);
      rst_i = 1'b1;
      step(3);
      rst_i = 1'b0;
      step(30);
      chk("hold_rst_held", held_rise[0], -1);
      chk("hold_rst_events", total(0), 0);
      button_i = 2'b00;
      step(30);
      chk("hold_rst_release_events", total(0), 0);
      button_i = 2'b01;
      step(12);
      button_i = 2'b00;
      step(40);
      $display("held-through-reset: short=%0d long=%0d", n_short[0], n_long[0]);
      chk("hold_rst_next_short", n_short[0], 1);
      chk("hold_rst_next_long", n_long[0], 0);

      // Reset mid-press on ch1 aborts without any event.
      clear_stats();
      button_i = 2'b10;
      step(15);
      rst_i = 1'b1;
      step(2);
      rst_i = 1'b0;
      step(30);
      button_i = 2'b00;
      step(40);
      $display("mid-press reset: events ch1=%0d", total(1));
      chk("midrst_events", total(1), 0);
      chk("midrst_held_seen", held_rise[1] >= 0 ? 1 : 0, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
